joy_db15_tx: RTL and testbench

- Device-side end of the DB15 serial joystick link. It emulates the adapter shift register that the core-side DB15 reader polls.
- Input is two parallel active-high joystick words. On the host's load/clock strobes it serialises them onto the active-low data line.
- Used in two places: as the bench model for the DB15 reader, and in adapter/bridge cores that output pad state over the user port.

---
 rtl/joy_db15_tx_if.sv | 28 ++
 rtl/joy_db15_tx.sv | 120 ++++++++++++
 tb/tb_joy_db15_tx.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/joy_db15_tx_if.sv
// rtl/joy_db15_tx_if.sv - DB15 joystick link signal bundle
// Purpose: groups the pad words, host strobes and serial/status outputs of joy_db15_tx.
// Signals:
//   joystick1, joystick2 [15:0] : pad words, active-high (driven by master)
//   JOY_CLK                     : host shift clock, asynchronous (driven by master)
//   JOY_LOAD                    : host load strobe, asynchronous, active-low (driven by master)
//   JOY_DATA                    : serial data, active-low (driven by slave)
//   frame_done                  : one-cycle pulse at end of frame (driven by slave)
//   busy                        : high while loading or shifting (driven by slave)
interface joy_db15_tx_if;
   logic [15:0] joystick1;
   logic [15:0] joystick2;
   logic        JOY_CLK;
   logic        JOY_LOAD;
   logic        JOY_DATA;
   logic        frame_done;
   logic        busy;

   modport master (
      output joystick1, joystick2, JOY_CLK, JOY_LOAD,
      input  JOY_DATA, frame_done, busy
   );

   modport slave (
      input  joystick1, joystick2, JOY_CLK, JOY_LOAD,
      output JOY_DATA, frame_done, busy
   );
endinterface

// File: rtl/joy_db15_tx.sv
// rtl/joy_db15_tx.sv - DB15 joystick adapter shift register emulation
// Purpose: serialises two parallel joystick words onto the active-low DB15 data line
//          under control of the host's JOY_LOAD / JOY_CLK strobes.
// Ports:
//   clk          : system clock, at least 8x the JOY_CLK rate
//   reset        : synchronous, active-high
//   bus (slave)  : joystick1/2 in, JOY_CLK/JOY_LOAD in, JOY_DATA/frame_done/busy out
//   frame_count  : [15:0] completed frames, wrapping (only with JOY_DB15_TX_STATS_EN)
//   abort_count  : [7:0] frames aborted by JOY_LOAD, saturating (only with JOY_DB15_TX_STATS_EN)
// Parameters: BITS_PER_PLAYER (4..16), SYNC_STAGES (2..3)
// Optional feature macro: JOY_DB15_TX_STATS_EN
module joy_db15_tx #(
   parameter int BITS_PER_PLAYER = 12,
   parameter int SYNC_STAGES     = 2
) (
   input  logic         clk,
   input  logic         reset,
`ifdef JOY_DB15_TX_STATS_EN
   output logic [15:0]  frame_count,
   output logic [7:0]   abort_count,
`endif
   joy_db15_tx_if.slave bus
);
   localparam int FRAME_BITS = 2 * BITS_PER_PLAYER;
   localparam int CNT_W      = $clog2(FRAME_BITS);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

   state_t                  state, state_next;
   logic [SYNC_STAGES-1:0]  clk_sync, load_sync;
   logic                    clk_prev, load_prev;
   logic                    clk_s, load_s, clk_rise, load_rise;
   logic [FRAME_BITS-1:0]   sreg, sreg_next, load_word;
   logic [CNT_W-1:0]        cnt, cnt_next;
   logic                    done_next;
   logic                    frame_done_q;
   logic                    unused_hi;

   // Upper pad bits beyond BITS_PER_PLAYER are deliberately ignored.
   assign unused_hi = ^{bus.joystick1, bus.joystick2};

   assign load_word = {~bus.joystick2[BITS_PER_PLAYER-1:0], ~bus.joystick1[BITS_PER_PLAYER-1:0]};
   assign clk_s     = clk_sync[SYNC_STAGES-1];
   assign load_s    = load_sync[SYNC_STAGES-1];
   assign clk_rise  = clk_s & ~clk_prev;
   assign load_rise = load_s & ~load_prev;

   always_ff @(posedge clk) begin
      if (reset) begin
         clk_sync     <= '1;
         load_sync    <= '1;
         clk_prev     <= 1'b1;
         load_prev    <= 1'b1;
         state        <= S_IDLE;
         sreg         <= '1;
         cnt          <= '0;
         frame_done_q <= 1'b0;
      end else begin
         clk_sync     <= {clk_sync[SYNC_STAGES-2:0], bus.JOY_CLK};
         load_sync    <= {load_sync[SYNC_STAGES-2:0], bus.JOY_LOAD};
         clk_prev     <= clk_s;
         load_prev    <= load_s;
         state        <= state_next;
         sreg         <= sreg_next;
         cnt          <= cnt_next;
         frame_done_q <= done_next;
      end
   end

   always_comb begin
      state_next = state;
      sreg_next  = sreg;
      cnt_next   = cnt;
      done_next  = 1'b0;
      // A low load strobe wins in every state and throws away any partial frame.
      if (!load_s) begin
         state_next = S_LOAD;
         sreg_next  = load_word;
         cnt_next   = '0;
      end else begin
         case (state)
            S_LOAD: begin
               // Shift edges coinciding with the load release are ignored here.
               sreg_next = load_word;
               cnt_next  = '0;
               if (load_rise) state_next = S_SHIFT;
            end
            S_SHIFT: begin
               if (clk_rise) begin
                  sreg_next = {1'b1, sreg[FRAME_BITS-1:1]};
                  if (cnt == CNT_W'(FRAME_BITS - 1)) begin
                     state_next = S_DONE;
                     done_next  = 1'b1;
                  end else begin
                     cnt_next = cnt + CNT_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy       = (state == S_LOAD) || (state == S_SHIFT);
   assign bus.JOY_DATA   = bus.busy ? sreg[0] : 1'b1;
   assign bus.frame_done = frame_done_q;

`ifdef JOY_DB15_TX_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_count <= '0;
         abort_count <= '0;
      end else begin
         if (done_next) frame_count <= frame_count + 16'd1;
         if (state == S_SHIFT && state_next == S_LOAD && abort_count != 8'hFF)
            abort_count <= abort_count + 8'd1;
      end
   end
`endif
endmodule

// File: tb/tb_joy_db15_tx.sv
// tb/tb_joy_db15_tx.sv - self-checking bench for joy_db15_tx
module tb_joy_db15_tx;
   localparam int N = 12;
   localparam int W = 2 * N;

   logic clk = 1'b0;
   logic reset;

   joy_db15_tx_if bus_if();

`ifdef JOY_DB15_TX_STATS_EN
   logic [15:0] frame_count;
   logic [7:0]  abort_count;
`endif

   joy_db15_tx #(.BITS_PER_PLAYER(N), .SYNC_STAGES(2)) dut (
      .clk(clk),
      .reset(reset),
`ifdef JOY_DB15_TX_STATS_EN
      .frame_count(frame_count),
      .abort_count(abort_count),
`endif
      .bus(bus_if)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   int   fd_total = 0;
   logic exp_q[$];

   always @(negedge clk) if (bus_if.frame_done === 1'b1) fd_total++;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic host_load();
      bus_if.JOY_LOAD = 1'b0;
      tick(6);
      bus_if.JOY_LOAD = 1'b1;
      tick(6);
   endtask

   task automatic host_edge();
      bus_if.JOY_CLK = 1'b1;
      tick(5);
      bus_if.JOY_CLK = 1'b0;
      tick(5);
   endtask

   task automatic push_frame(input logic [15:0] j1, input logic [15:0] j2, input int edges);
      for (int i = 0; i < edges; i++) begin
         if (i < N)      exp_q.push_back(~j1[i]);
         else if (i < W) exp_q.push_back(~j2[i-N]);
         else            exp_q.push_back(1'b1);
      end
   endtask

   task automatic test_reset();
      logic [15:0] fc_exp;
      reset = 1'b1;
      bus_if.JOY_LOAD = 1'b1;
      bus_if.JOY_CLK = 1'b0;
      bus_if.joystick1 = 16'hFFFF;
      bus_if.joystick2 = 16'hFFFF;
      tick(3);
      checks++; if (bus_if.JOY_DATA !== 1'b1) begin errors++; $display("FAIL reset_data got %b want 1", bus_if.JOY_DATA); end
      checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus_if.busy); end
      checks++; if (bus_if.frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b want 0", bus_if.frame_done); end
`ifdef JOY_DB15_TX_STATS_EN
      fc_exp = 16'd0;
      checks++; if (frame_count !== fc_exp) begin errors++; $display("FAIL reset_frame_count got %0d want 0", frame_count); end
`else
      fc_exp = 16'd0;
`endif
      reset = 1'b0;
      tick(5);
      checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", bus_if.busy); end
      checks++; if (bus_if.JOY_DATA !== 1'b1) begin errors++; $display("FAIL idle_data got %b want 1 (fc %0d)", bus_if.JOY_DATA, fc_exp); end
   endtask

   task automatic test_basic_frame();
      int   fd0;
      logic e;
      bus_if.joystick1 = 16'h0005;
      bus_if.joystick2 = 16'h0800;
      host_load();
      push_frame(16'h0005, 16'h0800, W);
      fd0 = fd_total;
      for (int i = 0; i < W; i++) begin
         e = exp_q.pop_front();
         checks++; if (bus_if.JOY_DATA !== e) begin errors++; $display("FAIL basic_bit%0d got %b want %b", i, bus_if.JOY_DATA, e); end
         checks++; if (bus_if.busy !== 1'b1) begin errors++; $display("FAIL basic_busy%0d got %b want 1", i, bus_if.busy); end
         host_edge();
         if (i == W - 2) begin
            checks++; if (fd_total - fd0 !== 0) begin errors++; $display("FAIL basic_early_done got %0d want 0", fd_total - fd0); end
         end
      end
      checks++; if (fd_total - fd0 !== 1) begin errors++; $display("FAIL basic_frame_done got %0d want 1", fd_total - fd0); end
      checks++; if (bus_if.JOY_DATA !== 1'b1) begin errors++; $display("FAIL basic_after got %b want 1", bus_if.JOY_DATA); end
      checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL basic_done_busy got %b want 0", bus_if.busy); end
   endtask

   task automatic test_latency();
      int   fd0;
      logic d0, d1, e;
      bus_if.joystick1 = 16'h0001;
      bus_if.joystick2 = 16'h0000;
      host_load();
      push_frame(16'h0001, 16'h0000, W);
      fd0 = fd_total;
      d0 = exp_q.pop_front();
      d1 = exp_q.pop_front();
      checks++; if (bus_if.JOY_DATA !== d0) begin errors++; $display("FAIL lat_first got %b want %b", bus_if.JOY_DATA, d0); end
      bus_if.JOY_CLK = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk); #1;
         e = (k == 3) ? d1 : d0;
         checks++; if (bus_if.JOY_DATA !== e) begin errors++; $display("FAIL lat_edge%0d got %b want %b", k, bus_if.JOY_DATA, e); end
         checks++; if (bus_if.busy !== 1'b1) begin errors++; $display("FAIL lat_busy%0d got %b want 1", k, bus_if.busy); end
      end
      tick(3);
      bus_if.JOY_CLK = 1'b0;
      tick(5);
      for (int i = 2; i < W; i++) begin
         host_edge();
         e = exp_q.pop_front();
         checks++; if (bus_if.JOY_DATA !== e) begin errors++; $display("FAIL lat_bit%0d got %b want %b", i, bus_if.JOY_DATA, e); end
      end
      host_edge();
      checks++; if (fd_total - fd0 !== 1) begin errors++; $display("FAIL lat_frame_done got %0d want 1", fd_total - fd0); end
   endtask

   task automatic test_abort();
      int          fd0;
      logic        e;
      logic [15:0] j1, j2;
`ifdef JOY_DB15_TX_STATS_EN
      logic [7:0]  ab0;
`endif
      j1 = 16'(($urandom & 32'hFFE) | 32'h1);
      j2 = 16'($urandom);
      bus_if.joystick1 = j1;
      bus_if.joystick2 = j2;
      host_load();
      push_frame(j1, j2, W);
      fd0 = fd_total;
`ifdef JOY_DB15_TX_STATS_EN
      ab0 = abort_count;
`endif
      for (int i = 0; i < 7; i++) begin
         e = exp_q.pop_front();
         checks++; if (bus_if.JOY_DATA !== e) begin errors++; $display("FAIL abort_pre%0d got %b want %b", i, bus_if.JOY_DATA, e); end
         host_edge();
      end
      exp_q.delete();
      bus_if.JOY_LOAD = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         checks++; if (bus_if.busy !== 1'b1) begin errors++; $display("FAIL abort_busy%0d got %b want 1", k, bus_if.busy); end
      end
      bus_if.JOY_LOAD = 1'b1;
      tick(6);
      checks++; if (fd_total - fd0 !== 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", fd_total - fd0); end
`ifdef JOY_DB15_TX_STATS_EN
      checks++; if (abort_count - ab0 !== 8'd1) begin errors++; $display("FAIL abort_count got %0d want %0d", abort_count, ab0 + 8'd1); end
`endif
      push_frame(j1, j2, W);
      for (int i = 0; i < W; i++) begin
         e = exp_q.pop_front();
         checks++; if (bus_if.JOY_DATA !== e) begin errors++; $display("FAIL abort_re%0d got %b want %b", i, bus_if.JOY_DATA, e); end
         host_edge();
      end
      checks++; if (fd_total - fd0 !== 1) begin errors++; $display("FAIL abort_frame_done got %0d want 1", fd_total - fd0); end
   endtask

   task automatic test_overclock();
      int          fd0;
      logic        e;
      logic [15:0] j1, j2;
      j1 = 16'h0A5C;
      j2 = 16'h03C1;
      bus_if.joystick1 = j1;
      bus_if.joystick2 = j2;
      host_load();
      push_frame(j1, j2, W + 6);
      fd0 = fd_total;
      for (int i = 0; i < W + 6; i++) begin
         e = exp_q.pop_front();
         checks++; if (bus_if.JOY_DATA !== e) begin errors++; $display("FAIL over_bit%0d got %b want %b", i, bus_if.JOY_DATA, e); end
         host_edge();
      end
      checks++; if (bus_if.JOY_DATA !== 1'b1) begin errors++; $display("FAIL over_after got %b want 1", bus_if.JOY_DATA); end
      checks++; if (fd_total - fd0 !== 1) begin errors++; $display("FAIL over_frame_done got %0d want 1", fd_total - fd0); end
      checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL over_busy got %b want 0", bus_if.busy); end
   endtask

   task automatic test_live_load();
      bus_if.joystick1 = 16'h0000;
      bus_if.joystick2 = 16'h0000;
      bus_if.JOY_LOAD = 1'b0;
      tick(6);
      bus_if.JOY_LOAD = 1'b1;
      bus_if.joystick1[0] = 1'b1;
      @(negedge clk);
      bus_if.joystick1[0] = 1'b0;
      @(negedge clk);
      bus_if.joystick1[0] = 1'b1;  // present in the cycle the synced load edge is seen
      @(negedge clk);
      bus_if.joystick1[0] = 1'b0;
      checks++; if (bus_if.JOY_DATA !== 1'b0) begin errors++; $display("FAIL live_first got %b want 0", bus_if.JOY_DATA); end
      tick(3);
      checks++; if (bus_if.JOY_DATA !== 1'b0) begin errors++; $display("FAIL live_hold got %b want 0", bus_if.JOY_DATA); end
      repeat (W) host_edge();
   endtask

   task automatic test_reset_mid_shift();
      int fd0;
      bus_if.joystick1 = 16'h0FFF;
      bus_if.joystick2 = 16'h0FFF;
      host_load();
      repeat (10) host_edge();
      fd0 = fd_total;
      checks++; if (bus_if.JOY_DATA !== 1'b0) begin errors++; $display("FAIL rst_pre_data got %b want 0", bus_if.JOY_DATA); end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++; if (bus_if.JOY_DATA !== 1'b1) begin errors++; $display("FAIL rst_data got %b want 1", bus_if.JOY_DATA); end
      checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", bus_if.busy); end
`ifdef JOY_DB15_TX_STATS_EN
      checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL rst_frame_count got %0d want 0", frame_count); end
`endif
      repeat (4) host_edge();
      checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL rst_idle_busy got %b want 0", bus_if.busy); end
      checks++; if (bus_if.JOY_DATA !== 1'b1) begin errors++; $display("FAIL rst_idle_data got %b want 1", bus_if.JOY_DATA); end
      checks++; if (fd_total - fd0 !== 0) begin errors++; $display("FAIL rst_no_done got %0d want 0", fd_total - fd0); end
   endtask

   task automatic test_back_to_back();
      int          fd0;
      logic        e;
      logic [15:0] j1, j2;
      fd0 = fd_total;
      for (int f = 0; f < 2; f++) begin
         j1 = 16'($urandom);
         j2 = 16'($urandom);
         bus_if.joystick1 = j1;
         bus_if.joystick2 = j2;
         host_load();
         push_frame(j1, j2, W);
         for (int i = 0; i < W; i++) begin
            e = exp_q.pop_front();
            checks++; if (bus_if.JOY_DATA !== e) begin errors++; $display("FAIL b2b_f%0d_bit%0d got %b want %b", f, i, bus_if.JOY_DATA, e); end
            host_edge();
         end
      end
      checks++; if (fd_total - fd0 !== 2) begin errors++; $display("FAIL b2b_frame_done got %0d want 2", fd_total - fd0); end
      checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_left got %0d want 0", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_latency();
      test_abort();
      test_overclock();
      test_live_load();
      test_reset_mid_shift();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
